compare_tree: RTL and testbench
===============================

Name: compare_tree

Overview:
- Pipelined N-channel magnitude comparator; generalises the team's single-pair 6-bit less-than compare.
- Each accepted transaction carries NUM_CH operands of WIDTH bits. The block returns the winning operand (min or max) and its channel index.
- Signed/unsigned and min/max are selectable per transaction.
- Sits between operand-gather logic and downstream scheduling/selection logic, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 6, operand width in bits (>=1).
- NUM_CH, 8, number of operands per transaction (>=1; need not be a power of two).
- IDX_W, $clog2(NUM_CH) (min 1), width of the index output; derived, not overridden.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  input transaction valid.
- o_ready  out  1  block can accept a transaction this cycle.
- i_data  in  NUM_CH*WIDTH  packed operands; channel k at [k*WIDTH +: WIDTH].
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- i_max  in  1  1 = select maximum, 0 = select minimum.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_value  out  WIDTH  winning operand, bit-exact copy of the input.
- o_index  out  IDX_W  channel index of the winner.
- o_all_eq  out  1  all NUM_CH operands were equal.

Behaviour:
- One tree level per register stage. LAT = max(1, $clog2(NUM_CH)) stages; NUM_CH=8 gives LAT=3.
- Accept: i_valid & o_ready on a rising edge. The result appears with o_valid=1 exactly LAT cycles later, if i_ready has been high throughout.
- Global advance: adv = ~o_valid | i_ready. All stages shift together when adv=1 and hold when adv=0. o_ready = adv (combinational). Bubbles propagate as per-stage valid=0.
- Throughput: 1 transaction/cycle when i_ready is held high.
- Pairing: each level pairs entries (2j, 2j+1).
  - An odd leftover entry passes through unchanged with its index.
  - Per-stage registers carry value, index, all_eq, signed and max mode bits.
- Compare rule:
  - Unsigned: plain magnitude compare.
  - Signed: MSB inverted on both operands, then unsigned compare.
  - i_max=0 selects the smaller operand; i_max=1 selects the larger.
  - Tie (equal values): the lower index always wins, in both modes.
- all_eq: AND of the child all_eq flags and equality of the two child values; a single leaf is 1.
- Mode bits are latched with the data and travel with the transaction. Changing i_signed/i_max between accepts affects only later transactions.
- While o_valid=1 and i_ready=0: o_value, o_index and o_all_eq hold stable, and no input is accepted.
- NUM_CH=1: single register stage; o_index=0, o_all_eq=1, o_value = i_data.
- Reset (any cycle, mid-stream included):
  - All stage valids clear next edge; o_valid=0, o_value=0, o_index=0, o_all_eq=0.
  - Transactions in flight are discarded.
  - o_ready=1 in the first cycle after reset deasserts.
- Reset has priority over accept: i_valid during i_rst is ignored.
- No X propagation: datapath registers of invalid stages may hold stale values, but outputs are gated to 0 when o_valid=0.

Test Plan:
- Unsigned min, NUM_CH=8, WIDTH=6: operands ch0..7 = {12,40,7,63,7,20,33,9}, i_signed=0, i_max=0 -> after 3 cycles o_valid=1, o_value=7, o_index=2 (tie with ch4 goes to the lower index), o_all_eq=0.
- Signed max vs unsigned max on the same data {6'h3F,6'h01,6'h20,6'h1F,0,0,0,0}:
  - signed -> o_value=6'h1F, o_index=3.
  - unsigned -> o_value=6'h3F, o_index=0.
- All equal: every channel = 6'h15, i_max=1 -> o_value=6'h15, o_index=0, o_all_eq=1.
- Back-to-back with backpressure: 5 consecutive accepts with alternating modes; hold i_ready=0 for 4 cycles mid-stream.
  - o_ready=0 while o_valid=1 and i_ready=0.
  - Outputs are stable during the hold.
  - All 5 results arrive in order, each matching its own mode; none lost or duplicated.
- Reset mid-operation: accept 2 transactions, assert i_rst on the next cycle for 1 cycle.
  - o_valid=0 from the following edge; neither result ever appears.
  - o_ready=1 after reset; a new transaction completes with latency 3.
- Parameter sweep NUM_CH=5, WIDTH=4, and NUM_CH=1: random operands over 1000 transactions checked against a reference model.
  - NUM_CH=5: LAT=3, leftover ch4 handled correctly.
  - NUM_CH=1: LAT=1, o_index=0.

Source files
------------

// File: rtl/compare_tree.sv
// Pipelined N-channel min/max comparator tree: one pairwise tree level per register stage,
// returning the winning operand, its channel index and an all-equal flag.
module compare_tree #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned NUM_CH = 8,
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    input  logic                    i_signed,
    input  logic                    i_max,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_value,
    output logic [IDX_W-1:0]        o_index,
    output logic                    o_all_eq
);

    localparam int unsigned LAT = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef logic [WIDTH-1:0] val_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam val_t MsbMask = val_t'(1) << (WIDTH - 1);

    // Level l sees the entries produced by level l-1 (level 0 sees the raw operands).
    val_t src_val [LAT][NUM_CH];
    idx_t src_idx [LAT][NUM_CH];
    logic src_eq  [LAT][NUM_CH];

    val_t val_d [LAT][NUM_CH];
    val_t val_q [LAT][NUM_CH];
    idx_t idx_d [LAT][NUM_CH];
    idx_t idx_q [LAT][NUM_CH];
    logic eq_d  [LAT][NUM_CH];
    logic eq_q  [LAT][NUM_CH];

    logic [LAT-1:0] vld_d, vld_q;
    logic [LAT-1:0] sgn_d, sgn_q;
    logic [LAT-1:0] max_d, max_q;

    logic adv;
    logic unused_mode;

    function automatic int level_count(input int lvl);
        int c;
        c = NUM_CH;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Signed order equals unsigned order once both MSBs are flipped. Ties keep a (lower index).
    function automatic logic b_wins(input val_t a, input val_t b, input logic sgn, input logic mx);
        val_t ka;
        val_t kb;
        ka = sgn ? (a ^ MsbMask) : a;
        kb = sgn ? (b ^ MsbMask) : b;
        return mx ? (kb > ka) : (kb < ka);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            src_val[0][k] = i_data[k*WIDTH +: WIDTH];
            src_idx[0][k] = idx_t'(k);
            src_eq[0][k]  = 1'b1;
        end
        vld_d[0] = i_valid;
        sgn_d[0] = i_signed;
        max_d[0] = i_max;
        for (int l = 1; l < LAT; l++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                src_val[l][k] = val_q[l-1][k];
                src_idx[l][k] = idx_q[l-1][k];
                src_eq[l][k]  = eq_q[l-1][k];
            end
            vld_d[l] = vld_q[l-1];
            sgn_d[l] = sgn_q[l-1];
            max_d[l] = max_q[l-1];
        end
    end

    always_comb begin
        for (int l = 0; l < LAT; l++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                int cnt;
                int a;
                int b;
                val_d[l][j] = '0;
                idx_d[l][j] = '0;
                eq_d[l][j]  = 1'b0;
                cnt = level_count(l);
                a   = (2 * j < NUM_CH) ? 2 * j : 0;
                b   = (2 * j + 1 < NUM_CH) ? 2 * j + 1 : a;
                if (2 * j + 1 < cnt) begin
                    if (b_wins(src_val[l][a], src_val[l][b], sgn_d[l], max_d[l])) begin
                        val_d[l][j] = src_val[l][b];
                        idx_d[l][j] = src_idx[l][b];
                    end else begin
                        val_d[l][j] = src_val[l][a];
                        idx_d[l][j] = src_idx[l][a];
                    end
                    eq_d[l][j] = src_eq[l][a] & src_eq[l][b] & (src_val[l][a] == src_val[l][b]);
                end else if (2 * j < cnt) begin
                    val_d[l][j] = src_val[l][a];
                    idx_d[l][j] = src_idx[l][a];
                    eq_d[l][j]  = src_eq[l][a];
                end
            end
        end
    end

    assign o_valid = vld_q[LAT-1];
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    // Datapath carries no reset; stale contents are masked by the stage valids.
    always_ff @(posedge i_clk) begin
        if (adv) begin
            val_q <= val_d;
            idx_q <= idx_d;
            eq_q  <= eq_d;
            sgn_q <= sgn_d;
            max_q <= max_d;
        end
    end

    assign o_value  = o_valid ? val_q[LAT-1][0] : '0;
    assign o_index  = o_valid ? idx_q[LAT-1][0] : '0;
    assign o_all_eq = o_valid ? eq_q[LAT-1][0] : 1'b0;

    assign unused_mode = ^{sgn_q[LAT-1], max_q[LAT-1]};

endmodule

// File: tb/tb_compare_tree.sv
// Scoreboard bench for compare_tree: directed vectors on an 8x6 instance plus randomised
// model-checked runs on 5x4 and 1x6 instances.
module tb_compare_tree;

    typedef struct {
        int value;
        int index;
        int all_eq;
        int acc;
        bit lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q8[$];
    exp_t q5[$];
    exp_t q1[$];
    exp_t e8, e5, e1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- 8 x 6 instance ----------------
    logic        rst8 = 1'b1, v8 = 1'b0, s8 = 1'b0, m8 = 1'b0, ir8 = 1'b1;
    logic [47:0] d8 = '0;
    logic        rdy8, ov8, eq8;
    logic [5:0]  val8;
    logic [2:0]  idx8;

    compare_tree #(.WIDTH(6), .NUM_CH(8)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_valid(v8), .o_ready(rdy8), .i_data(d8),
        .i_signed(s8), .i_max(m8), .o_valid(ov8), .i_ready(ir8), .o_value(val8),
        .o_index(idx8), .o_all_eq(eq8)
    );

    // ---------------- 5 x 4 instance ----------------
    logic        rst5 = 1'b1, v5 = 1'b0, s5 = 1'b0, m5 = 1'b0, ir5 = 1'b1;
    logic [19:0] d5 = '0;
    logic        rdy5, ov5, eq5;
    logic [3:0]  val5;
    logic [2:0]  idx5;

    compare_tree #(.WIDTH(4), .NUM_CH(5)) dut5 (
        .i_clk(clk), .i_rst(rst5), .i_valid(v5), .o_ready(rdy5), .i_data(d5),
        .i_signed(s5), .i_max(m5), .o_valid(ov5), .i_ready(ir5), .o_value(val5),
        .o_index(idx5), .o_all_eq(eq5)
    );

    // ---------------- 1 x 6 instance ----------------
    logic        rst1 = 1'b1, v1 = 1'b0, s1 = 1'b0, m1 = 1'b0, ir1 = 1'b1;
    logic [5:0]  d1 = '0;
    logic        rdy1, ov1, eq1;
    logic [5:0]  val1;
    logic [0:0]  idx1;

    compare_tree #(.WIDTH(6), .NUM_CH(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_valid(v1), .o_ready(rdy1), .i_data(d1),
        .i_signed(s1), .i_max(m1), .o_valid(ov1), .i_ready(ir1), .o_value(val1),
        .o_index(idx1), .o_all_eq(eq1)
    );

    // ---------------- monitors ----------------
    always begin
        @(negedge clk);
        #2;
        if (!rst8 && ov8 && ir8) begin
            if (q8.size() == 0) begin
                chk("dut8 unexpected result", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("dut8 value", int'(val8), e8.value);
                chk("dut8 index", int'(idx8), e8.index);
                chk("dut8 all_eq", int'(eq8), e8.all_eq);
                if (e8.lat) chk("dut8 latency", cyc - e8.acc, 3);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst5 && ov5 && ir5) begin
            if (q5.size() == 0) begin
                chk("dut5 unexpected result", 1, 0);
            end else begin
                e5 = q5.pop_front();
                chk("dut5 value", int'(val5), e5.value);
                chk("dut5 index", int'(idx5), e5.index);
                chk("dut5 all_eq", int'(eq5), e5.all_eq);
                if (e5.lat) chk("dut5 latency", cyc - e5.acc, 3);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst1 && ov1 && ir1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected result", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 value", int'(val1), e1.value);
                chk("dut1 index", int'(idx1), e1.index);
                chk("dut1 all_eq", int'(eq1), e1.all_eq);
                if (e1.lat) chk("dut1 latency", cyc - e1.acc, 1);
            end
        end
    end

    // ---------------- reference model (linear scan, first best wins) ----------------
    function automatic int sval(input int x, input int w, input bit sg);
        if (sg && x >= (1 << (w - 1))) return x - (1 << w);
        return x;
    endfunction

    function automatic exp_t model(input int ops[8], input int n, input int w,
                                   input bit sg, input bit mx);
        exp_t r;
        int best;
        best     = 0;
        r.all_eq = 1;
        for (int k = 1; k < n; k++) begin
            if (ops[k] != ops[0]) r.all_eq = 0;
            if (mx ? (sval(ops[k], w, sg) > sval(ops[best], w, sg))
                   : (sval(ops[k], w, sg) < sval(ops[best], w, sg))) best = k;
        end
        r.value = ops[best];
        r.index = best;
        r.acc   = 0;
        r.lat   = 1'b0;
        return r;
    endfunction

    // ---------------- dut8 drivers ----------------
    task automatic send8(input logic [47:0] d, input bit sg, input bit mx, input bit want,
                         input int ev, input int ei, input int eeq, input bit lat);
        @(negedge clk);
        v8 = 1'b1;
        d8 = d;
        s8 = sg;
        m8 = mx;
        #1;
        for (int t = 0; !rdy8; t++) begin
            if (t >= 50) begin
                chk("dut8 accept timeout", 0, 1);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        if (want) q8.push_back(exp_t'{ev, ei, eeq, cyc, lat});
    endtask

    task automatic idle8(input int n);
        @(negedge clk);
        v8 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (q8.size() == 0 && q5.size() == 0 && q1.size() == 0) return;
            @(negedge clk);
        end
        chk("drain timeout", q8.size() + q5.size() + q1.size(), 0);
    endtask

    localparam logic [47:0] D1 = {6'd9, 6'd33, 6'd20, 6'd7, 6'd63, 6'd7, 6'd40, 6'd12};
    localparam logic [47:0] D2 = {6'h00, 6'h00, 6'h00, 6'h00, 6'h1F, 6'h20, 6'h01, 6'h3F};
    localparam logic [47:0] D3 = {8{6'h15}};

    logic [5:0] cv;
    logic [2:0] ci;
    logic       ce;

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset o_valid", int'(ov8), 0);
        chk("reset o_value", int'(val8), 0);
        rst8 = 1'b0;
        rst5 = 1'b0;
        rst1 = 1'b0;
        #2;
        chk("post-reset o_ready", int'(rdy8), 1);
        chk("post-reset o_valid", int'(ov8), 0);
        chk("post-reset o_index", int'(idx8), 0);
        chk("post-reset o_all_eq", int'(eq8), 0);

        // unsigned min with a tie between ch2 and ch4
        send8(D1, 1'b0, 1'b0, 1'b1, 7, 2, 0, 1'b1);
        idle8(5);
        // signed max vs unsigned max, back to back
        send8(D2, 1'b1, 1'b1, 1'b1, 6'h1F, 3, 0, 1'b1);
        send8(D2, 1'b0, 1'b1, 1'b1, 6'h3F, 0, 0, 1'b1);
        // all equal
        send8(D3, 1'b0, 1'b1, 1'b1, 6'h15, 0, 1, 1'b1);
        idle8(1);
        drain();

        // back-to-back with a 4-cycle downstream stall
        fork
            begin
                send8(D2, 1'b0, 1'b0, 1'b1, 6'h00, 4, 0, 1'b0);
                send8(D2, 1'b1, 1'b1, 1'b1, 6'h1F, 3, 0, 1'b0);
                send8(D2, 1'b0, 1'b1, 1'b1, 6'h3F, 0, 0, 1'b0);
                send8(D2, 1'b1, 1'b0, 1'b1, 6'h20, 2, 0, 1'b0);
                send8(D2, 1'b0, 1'b0, 1'b1, 6'h00, 4, 0, 1'b0);
                idle8(1);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!ov8 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("stall first result valid", int'(ov8), 1);
                ir8 = 1'b0;
                #2;
                cv = val8;
                ci = idx8;
                ce = eq8;
                for (int k = 0; k < 4; k++) begin
                    chk("stall o_ready", int'(rdy8), 0);
                    chk("stall o_valid", int'(ov8), 1);
                    chk("stall o_value stable", int'(val8), int'(cv));
                    chk("stall o_index stable", int'(idx8), int'(ci));
                    chk("stall o_all_eq stable", int'(eq8), int'(ce));
                    @(negedge clk);
                    if (k < 3) #2;
                end
                ir8 = 1'b1;
            end
        join
        drain();

        // reset kills two in-flight transactions
        send8(D1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        send8(D2, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        v8   = 1'b0;
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        #2;
        chk("mid-reset o_valid", int'(ov8), 0);
        chk("mid-reset o_value", int'(val8), 0);
        chk("mid-reset o_index", int'(idx8), 0);
        chk("mid-reset o_all_eq", int'(eq8), 0);
        chk("mid-reset o_ready", int'(rdy8), 1);
        repeat (6) @(negedge clk);
        send8(D1, 1'b0, 1'b1, 1'b1, 63, 3, 0, 1'b1);
        idle8(1);
        drain();

        // parameter sweep instances, randomised operands, modes and backpressure
        fork
            for (int i = 0; i < 1000; i++) begin
                int   ops[8];
                exp_t r;
                @(negedge clk);
                for (int k = 0; k < 8; k++) ops[k] = (k < 5) ? $urandom_range(0, 15) : 0;
                for (int k = 0; k < 5; k++) d5[k*4 +: 4] = ops[k][3:0];
                s5  = 1'($urandom_range(0, 1));
                m5  = 1'($urandom_range(0, 1));
                v5  = 1'b1;
                ir5 = ($urandom_range(0, 3) != 0);
                #1;
                for (int t = 0; !rdy5; t++) begin
                    if (t >= 20) begin
                        chk("dut5 accept timeout", 0, 1);
                        break;
                    end
                    @(negedge clk);
                    ir5 = 1'b1;
                    #1;
                end
                @(posedge clk);
                r = model(ops, 5, 4, s5, m5);
                q5.push_back(r);
                if (i == 999) begin
                    @(negedge clk);
                    v5  = 1'b0;
                    ir5 = 1'b1;
                end
            end
            for (int i = 0; i < 1000; i++) begin
                int   ops[8];
                exp_t r;
                @(negedge clk);
                for (int k = 0; k < 8; k++) ops[k] = (k == 0) ? $urandom_range(0, 63) : 0;
                d1  = ops[0][5:0];
                s1  = 1'($urandom_range(0, 1));
                m1  = 1'($urandom_range(0, 1));
                v1  = 1'b1;
                ir1 = ($urandom_range(0, 3) != 0);
                #1;
                for (int t = 0; !rdy1; t++) begin
                    if (t >= 20) begin
                        chk("dut1 accept timeout", 0, 1);
                        break;
                    end
                    @(negedge clk);
                    ir1 = 1'b1;
                    #1;
                end
                @(posedge clk);
                r = model(ops, 1, 6, s1, m1);
                q1.push_back(r);
                if (i == 999) begin
                    @(negedge clk);
                    v1  = 1'b0;
                    ir1 = 1'b1;
                end
            end
        join
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
